// File: rtl/i2s_frame_sequencer.sv
// Master-mode I2S frame controller: derives BCLK/WCLK from MCLK, serialises one
// stereo TX frame per WCLK period and captures the incoming stereo ADC frame.
module i2s_frame_sequencer #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_HALF = 4
) (
  input  logic             MCLK_IN,
  input  logic             RESET_N_IN,
  input  logic             EN_IN,
  input  logic [WIDTH-1:0] TX_L_DATA,
  input  logic [WIDTH-1:0] TX_R_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic             I2S_BCLK_OUT,
  output logic             I2S_WCLK_OUT,
  output logic             I2S_DOUT,
  input  logic             I2S_DIN,
  output logic [WIDTH-1:0] RX_L_DATA,
  output logic [WIDTH-1:0] RX_R_DATA,
  output logic             RX_VALID,
  output logic             UNDERRUN_OUT
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int RXW   = SLOT_BITS + WIDTH;
  localparam int CW    = $clog2(BCLK_HALF);
  localparam int NW    = $clog2(FRAME);

  logic [CW-1:0]    bclk_cnt_r;
  logic             bclk_r;
  logic [NW-1:0]    bit_cnt_r;
  logic             wclk_r;
  logic             dout_r;
  logic [FRAME-1:0] tx_sh_r;
  logic [RXW-1:0]   rx_sh_r;
  logic             rx_done_r;
  logic             hold_full_r;
  logic [WIDTH-1:0] hold_l_r;
  logic [WIDTH-1:0] hold_r_r;
  logic             underrun_r;
  logic             rx_valid_r;
  logic [WIDTH-1:0] rx_l_r;
  logic [WIDTH-1:0] rx_r_r;

  logic             wrap_s;
  logic             re_s;
  logic             fe_s;
  logic             xfer_s;
  logic             accept_s;
  logic [NW-1:0]    bit_next_s;
  logic             wclk_next_s;
  logic [FRAME-1:0] frame_s;

  // Strobes, next bit position and the frame image loaded at n = 0
  always_comb begin
    wrap_s     = (bclk_cnt_r == CW'(BCLK_HALF - 1));
    re_s       = EN_IN & wrap_s & ~bclk_r;
    fe_s       = EN_IN & wrap_s & bclk_r;
    xfer_s     = fe_s & (bit_cnt_r == NW'(FRAME - 1));
    accept_s   = TX_VALID & ~hold_full_r;
    if (bit_cnt_r == NW'(FRAME - 1)) begin
      bit_next_s = '0;
    end else begin
      bit_next_s = bit_cnt_r + NW'(1);
    end
    // WCLK leads the MSB of each slot by one bit
    wclk_next_s = (bit_next_s >= NW'(SLOT_BITS - 1)) && (bit_next_s <= NW'(FRAME - 2));
    frame_s     = '0;
    if (hold_full_r) begin
      frame_s[FRAME-1 -: WIDTH]     = hold_l_r;
      frame_s[SLOT_BITS-1 -: WIDTH] = hold_r_r;
    end else begin
      frame_s = '0;
    end
  end

  // Bit-clock divider, bit counter, serial outputs and RX shift register
  always_ff @(posedge MCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      bclk_cnt_r <= '0;
      bclk_r     <= 1'b0;
      bit_cnt_r  <= NW'(FRAME - 1);
      wclk_r     <= 1'b0;
      dout_r     <= 1'b0;
      tx_sh_r    <= '0;
      rx_sh_r    <= '0;
      rx_done_r  <= 1'b0;
    end else if (!EN_IN) begin
      bclk_cnt_r <= '0;
      bclk_r     <= 1'b0;
      bit_cnt_r  <= NW'(FRAME - 1);
      wclk_r     <= 1'b0;
      dout_r     <= 1'b0;
      tx_sh_r    <= '0;
      rx_sh_r    <= '0;
      rx_done_r  <= 1'b0;
    end else begin
      if (wrap_s) begin
        bclk_cnt_r <= '0;
        bclk_r     <= ~bclk_r;
      end else begin
        bclk_cnt_r <= bclk_cnt_r + CW'(1);
      end
      if (fe_s) begin
        bit_cnt_r <= bit_next_s;
        wclk_r    <= wclk_next_s;
        if (xfer_s) begin
          dout_r  <= frame_s[FRAME-1];
          tx_sh_r <= {frame_s[FRAME-2:0], 1'b0};
        end else begin
          dout_r  <= tx_sh_r[FRAME-1];
          tx_sh_r <= {tx_sh_r[FRAME-2:0], 1'b0};
        end
      end
      if (re_s) begin
        rx_sh_r <= {rx_sh_r[RXW-2:0], I2S_DIN};
      end
      rx_done_r <= re_s & (bit_cnt_r == NW'(SLOT_BITS + WIDTH - 1));
    end
  end

  // TX holding register; keeps handshaking while idle
  always_ff @(posedge MCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      hold_full_r <= 1'b0;
      hold_l_r    <= '0;
      hold_r_r    <= '0;
      underrun_r  <= 1'b0;
    end else begin
      underrun_r <= xfer_s & ~hold_full_r;
      if (accept_s) begin
        hold_full_r <= 1'b1;
        hold_l_r    <= TX_L_DATA;
        hold_r_r    <= TX_R_DATA;
      end else if (xfer_s) begin
        hold_full_r <= 1'b0;
      end
    end
  end

  // RX result registers, updated the cycle after the last right-slot bit
  always_ff @(posedge MCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      rx_valid_r <= 1'b0;
      rx_l_r     <= '0;
      rx_r_r     <= '0;
    end else begin
      rx_valid_r <= rx_done_r & EN_IN;
      if (rx_done_r & EN_IN) begin
        rx_l_r <= rx_sh_r[RXW-1 -: WIDTH];
        rx_r_r <= rx_sh_r[WIDTH-1:0];
      end
    end
  end

  assign TX_READY     = ~hold_full_r;
  assign I2S_BCLK_OUT = bclk_r;
  assign I2S_WCLK_OUT = wclk_r;
  assign I2S_DOUT     = dout_r;
  assign RX_L_DATA    = rx_l_r;
  assign RX_R_DATA    = rx_r_r;
  assign RX_VALID     = rx_valid_r;
  assign UNDERRUN_OUT = underrun_r;

endmodule
